mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, memory access cycles per transaction; legal range 1..7.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 if_req  in  1  fetch request; held high until if_done.
REQ-005 if_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_rdata  out  32  fetched word; valid while if_done=1.
REQ-007 if_done  out  1  one-cycle completion pulse for fetch.
REQ-008 d_req  in  1  data request from MEM stage; held high until d_done.
REQ-009 d_we  in  1  1=store, 0=load.
REQ-010 d_size  in  2  00 word, 01 byte, 10 halfword; 11 is treated as word.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data, right-justified.
REQ-013 d_rdata  out  32  raw big-endian memory word; valid while d_done=1.
REQ-014 d_done  out  1  one-cycle completion pulse for data.
REQ-015 mem_addr  out  32  word-aligned address to the shared memory port ({addr[31:2],2'b00}).
REQ-016 mem_wdata  out  32  replicated store data.
REQ-017 mem_we  out  1  write strobe.
REQ-018 mem_be  out  4  byte enables, bit 3 = byte at offset 0 (big-endian).
REQ-019 mem_rdata  in  32  read data from memory, valid in the final access cycle.
REQ-020 stall_if  out  1  combinational: if_req & ~if_done.
REQ-021 stall_mem  out  1  combinational: d_req & ~d_done.

Function
REQ-022 The FSM SHALL have states IDLE, ACCESS and RESP, plus a grant register (IF/D) and a 3-bit wait counter.
REQ-023 In IDLE with any request pending, the block SHALL latch the grant, address, size, we and wdata at the rising edge and enter ACCESS.
REQ-024 ACCESS SHALL last exactly WAIT_CYCLES cycles, with mem_addr, mem_be and mem_wdata stable throughout.
REQ-025 mem_we SHALL be high only in the final ACCESS cycle of a granted store; it SHALL be 0 otherwise.
REQ-026 In the final ACCESS cycle, mem_rdata SHALL be captured into the response register; the FSM then enters RESP.
REQ-027 RESP SHALL last one cycle, pulse the granted requester's done and drive its rdata; the FSM returns to IDLE.
REQ-028 Latency from request sampled in IDLE to done SHALL be WAIT_CYCLES+1 cycles; the minimum turnaround between grants is 1 IDLE cycle.
REQ-029 Byte enables: byte off0..3 -> 1000/0100/0010/0001; half addr[1]=0 -> 1100, =1 -> 0011; word -> 1111; halfword addr[0] ignored.
REQ-030 mem_wdata: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
REQ-031 A request dropped mid-transaction SHALL NOT abort it; the access completes and done still pulses.
REQ-032 If both requests are pending in IDLE, d_req SHALL win (default priority, see REQ-037).
REQ-033 Outside ACCESS, mem_be SHALL be 0000 and mem_we SHALL be 0.

Reset
REQ-034 Reset SHALL force IDLE, counter 0, grant=D, done pulses 0, mem_we 0, mem_be 0000, mem_addr 0, and both rdata outputs 0.
REQ-035 Reset asserted mid-ACCESS or mid-RESP SHALL abandon the transaction with no done pulse and no further mem_we, effective the next cycle.
REQ-036 The first grant SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-037 Macro MEM_ARB_FAIR_EN: when defined, contention in IDLE SHALL grant the requester not granted last (round-robin); when undefined, data SHALL always win (REQ-032).

Verification
REQ-038 WAIT_CYCLES=2, single if_req addr 0x100 with mem_rdata=0xDEADBEEF -> mem_addr 0x100 for 2 cycles, if_done pulse 3 cycles after grant, if_rdata=0xDEADBEEF, stall_if drops with done.
REQ-039 sb: d_size=01, d_addr 0x203, d_wdata 0x000000A5 -> mem_be 0001, mem_wdata 0xA5A5A5A5, mem_we high for exactly 1 cycle, d_done pulses once.
REQ-040 if_req and d_req raised together, both held; fair build off -> data then fetch; fair build on -> alternate across 4 back-to-back pairs.
REQ-041 sh at 0x402 with wdata 0x1234 -> mem_be 0011, mem_wdata 0x12341234, mem_addr 0x400.
REQ-042 Reset pulsed during the second ACCESS cycle of a store -> mem_we never asserted, no d_done, FSM in IDLE, and a new request is granted in the first cycle after reset.
REQ-043 if_req dropped after 1 ACCESS cycle -> transaction completes and if_done still pulses.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and shared-memory-port signals.
// The arbiter takes the slave side; requesters and memory take the master side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_rdata,
        output if_rdata, if_done,
        output d_rdata, d_done,
        output mem_addr, mem_wdata, mem_we, mem_be,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        output mem_rdata,
        input  if_rdata, if_done,
        input  d_rdata, d_done,
        input  mem_addr, mem_wdata, mem_we, mem_be,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters.
// Define MEM_ARB_FAIR_EN for round-robin on contention; otherwise data wins.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    logic        grant_d;
    logic        grant_d_nx;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nx;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_q;
    logic        pick_d;
    logic        start;
    logic        last;
    logic        resp_v;
    logic        if_done;
    logic        d_done;
    logic [3:0]  be;
    logic [31:0] wd;

    assign start = (state == IDLE)
                 & (bus.if_req | bus.d_req);
    assign last  = (state == ACCESS)
                 & (cnt == LAST);

`ifdef MEM_ARB_FAIR_EN
    // On contention, hand the port to whoever did not have it last.
    assign pick_d = bus.d_req
                  & (~bus.if_req | ~grant_d);
`else
    assign pick_d = bus.d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            grant_d <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            grant_d <= grant_d_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            wdata_q <= '0;
            resp_q  <= '0;
        end else begin
            if (start) begin
                addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
                size_q  <= pick_d ? bus.d_size : 2'b00;
                we_q    <= pick_d & bus.d_we;
                wdata_q <= pick_d ? bus.d_wdata : '0;
            end
            if (last) begin
                resp_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        grant_d_nx = grant_d;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = ACCESS;
                    cnt_nx     = 3'd0;
                    grant_d_nx = pick_d;
                end
            end
            ACCESS: begin
                if (cnt == LAST) begin
                    state_nx = RESP;
                    cnt_nx   = 3'd0;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Lane 3 is byte offset 0 (big-endian port).
    always_comb begin
        be = 4'b1111;
        wd = wdata_q;
        unique case (size_q)
            2'b01: begin
                be = 4'b1000 >> addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b10: begin
                be = addr_q[1] ? 4'b0011 : 4'b1100;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    // Reset wins in the same cycle so an abandoned store never writes.
    assign resp_v  = (state == RESP) & ~reset;
    assign if_done = resp_v & ~grant_d;
    assign d_done  = resp_v & grant_d;

    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = wd;
    assign bus.mem_be    = (state == ACCESS) ? be : 4'b0000;
    assign bus.mem_we    = last & we_q & ~reset;

    assign bus.if_done   = if_done;
    assign bus.d_done    = d_done;
    assign bus.if_rdata  = if_done ? resp_q : '0;
    assign bus.d_rdata   = d_done ? resp_q : '0;
    assign bus.stall_if  = bus.if_req & ~if_done;
    assign bus.stall_mem = bus.d_req & ~d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table for single transactions, plus
// sequences for contention, dropped request and reset mid-access.
module tb_mem_port_arbiter;
    localparam int W = 2;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vt[12];
    int   errors = 0;
    int   checks = 0;
    int   we_cycles = 0;
    int   exp_we = 0;
    logic last_d = 1'b1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) we_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic d, input logic we,
                                input logic [1:0] sz,
                                input logic [31:0] a,
                                input logic [31:0] wdt,
                                input logic [31:0] rd,
                                input logic [31:0] ea,
                                input logic [3:0] eb,
                                input logic [31:0] ew);
        vec_t v;
        v.is_d = d;
        v.we = we;
        v.size = sz;
        v.addr = a;
        v.wdata = wdt;
        v.rdata = rd;
        v.e_addr = ea;
        v.e_be = eb;
        v.e_wdata = ew;
        return v;
    endfunction

    // Entry and exit: #1 after a posedge, FSM idle next cycle.
    task automatic run_vec(input vec_t v, input int n);
        string t;
        t = $sformatf("v%0d", n);
        if (v.is_d) begin
            bus.d_req = 1'b1;
            bus.d_we = v.we;
            bus.d_size = v.size;
            bus.d_addr = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1;
            bus.if_addr = v.addr;
        end
        @(negedge clk);
        chk({t, "_idle_be"}, 32'(bus.mem_be), 32'h0);
        chk({t, "_stall"}, 32'(v.is_d ? bus.stall_mem : bus.stall_if), 32'h1);
        @(posedge clk);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            bus.mem_rdata = (k == W - 1) ? v.rdata : ~v.rdata;
            chk({t, "_addr"}, bus.mem_addr, v.e_addr);
            chk({t, "_be"}, 32'(bus.mem_be), 32'(v.e_be));
            if (v.we) chk({t, "_wdata"}, bus.mem_wdata, v.e_wdata);
            chk({t, "_we"}, 32'(bus.mem_we), 32'(v.we && (k == W - 1)));
            chk({t, "_done_early"}, 32'({bus.if_done, bus.d_done}), 32'h0);
        end
        @(negedge clk);
        chk({t, "_if_done"}, 32'(bus.if_done), 32'(!v.is_d));
        chk({t, "_d_done"}, 32'(bus.d_done), 32'(v.is_d));
        chk({t, "_rdata"}, v.is_d ? bus.d_rdata : bus.if_rdata, v.rdata);
        chk({t, "_resp_be"}, 32'(bus.mem_be), 32'h0);
        chk({t, "_stall_off"}, 32'(v.is_d ? bus.stall_mem : bus.stall_if), 32'h0);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        bus.if_req = 1'b0;
        last_d = v.is_d;
        @(negedge clk);
        chk({t, "_done_once"}, 32'({bus.if_done, bus.d_done}), 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input int p);
        logic        first_d;
        logic        cur_d;
        logic [31:0] ia;
        logic [31:0] da;
        string       t;
        t = $sformatf("pair%0d", p);
        first_d = FAIR ? ~last_d : 1'b1;
        ia = 32'h700 + 32'(p * 16);
        da = 32'h800 + 32'(p * 16);
        bus.if_req = 1'b1;
        bus.if_addr = ia;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_size = 2'b00;
        bus.d_addr = da;
        bus.mem_rdata = 32'h0;
        for (int g = 0; g < 2; g++) begin
            cur_d = (g == 0) ? first_d : ~first_d;
            @(posedge clk);
            @(negedge clk);
            chk({t, "_grant_addr"}, bus.mem_addr, cur_d ? da : ia);
            for (int k = 1; k < W; k++) @(negedge clk);
            @(negedge clk);
            chk({t, "_done"}, 32'({bus.if_done, bus.d_done}),
                cur_d ? 32'h1 : 32'h2);
            @(posedge clk);
            #1;
            if (cur_d) bus.d_req = 1'b0;
            else bus.if_req = 1'b0;
            @(negedge clk);
            chk({t, "_gap_be"}, 32'(bus.mem_be), 32'h0);
        end
        last_d = ~first_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_size = 2'b00;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.mem_rdata = '0;

        vt[0]  = mk(0, 0, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF,
                    32'h100, 4'b1111, 32'h0);
        vt[1]  = mk(0, 0, 2'b00, 32'h103, 32'h0, 32'h01234567,
                    32'h100, 4'b1111, 32'h0);
        vt[2]  = mk(1, 1, 2'b01, 32'h203, 32'h000000A5, 32'h0,
                    32'h200, 4'b0001, 32'hA5A5A5A5);
        vt[3]  = mk(1, 1, 2'b10, 32'h402, 32'h00001234, 32'h0,
                    32'h400, 4'b0011, 32'h12341234);
        vt[4]  = mk(1, 1, 2'b10, 32'h401, 32'hFFFFABCD, 32'h0,
                    32'h400, 4'b1100, 32'hABCDABCD);
        vt[5]  = mk(1, 1, 2'b01, 32'h300, 32'h12345678, 32'h0,
                    32'h300, 4'b1000, 32'h78787878);
        vt[6]  = mk(1, 1, 2'b01, 32'h301, 32'h000000C3, 32'h0,
                    32'h300, 4'b0100, 32'hC3C3C3C3);
        vt[7]  = mk(1, 1, 2'b01, 32'h302, 32'h0000005A, 32'h0,
                    32'h300, 4'b0010, 32'h5A5A5A5A);
        vt[8]  = mk(1, 1, 2'b00, 32'h500, 32'hCAFEF00D, 32'h0,
                    32'h500, 4'b1111, 32'hCAFEF00D);
        vt[9]  = mk(1, 1, 2'b11, 32'h506, 32'h11223344, 32'h0,
                    32'h504, 4'b1111, 32'h11223344);
        vt[10] = mk(1, 0, 2'b00, 32'h600, 32'h0, 32'h0BADCAFE,
                    32'h600, 4'b1111, 32'h0);
        vt[11] = mk(1, 0, 2'b01, 32'h601, 32'hFFFFFF00, 32'h11223344,
                    32'h600, 4'b0100, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_be", 32'(bus.mem_be), 32'h0);
        chk("rst_we", 32'(bus.mem_we), 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_done", 32'({bus.if_done, bus.d_done}), 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vt[i].we) exp_we++;
            run_vec(vt[i], i);
        end

        // Fetch request withdrawn after the first access cycle.
        bus.if_req = 1'b1;
        bus.if_addr = 32'hB00;
        @(posedge clk);
        @(negedge clk);
        chk("drop_addr", bus.mem_addr, 32'hB00);
        bus.mem_rdata = 32'h0F0F1234;
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        for (int k = 1; k < W; k++) @(negedge clk);
        @(negedge clk);
        chk("drop_done", 32'(bus.if_done), 32'h1);
        chk("drop_rdata", bus.if_rdata, 32'h0F0F1234);
        @(posedge clk);
        #1;
        last_d = 1'b0;
        @(negedge clk);
        chk("drop_done_once", 32'(bus.if_done), 32'h0);
        @(posedge clk);
        #1;

        // Reset during the second access cycle of a word store.
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_size = 2'b00;
        bus.d_addr = 32'h900;
        bus.d_wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        chk("rmid_acc1_we", 32'(bus.mem_we), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("rmid_acc2_we", 32'(bus.mem_we), 32'h0);
        chk("rmid_acc2_done", 32'(bus.d_done), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.if_req = 1'b1;
        bus.if_addr = 32'hA00;
        bus.mem_rdata = 32'h600DF00D;
        @(negedge clk);
        chk("rmid_idle_be", 32'(bus.mem_be), 32'h0);
        chk("rmid_no_done", 32'({bus.if_done, bus.d_done}), 32'h0);
        chk("rmid_addr_clr", bus.mem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rmid_regrant_addr", bus.mem_addr, 32'hA00);
        chk("rmid_regrant_be", 32'(bus.mem_be), 32'hF);
        for (int k = 1; k < W; k++) @(negedge clk);
        @(negedge clk);
        chk("rmid_if_done", 32'(bus.if_done), 32'h1);
        chk("rmid_if_rdata", bus.if_rdata, 32'h600DF00D);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        last_d = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;

        for (int p = 0; p < 4; p++) pair(p);

        chk("we_cycle_total", 32'(we_cycles), 32'(exp_we));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
